banked_burst_mem: RTL

BANKED_BURST_MEM -- requirements
Module: banked_burst_mem

---
 rtl/banked_mem_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 21 ++
 rtl/banked_burst_mem.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/banked_mem_pkg.sv
// banked_mem_pkg: shared state enum, parameter defaults and latency select for banked_burst_mem
package banked_mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_e;
    localparam int DEF_NUM_PORTS   = 2;
    localparam int DEF_LINE_WIDTH  = 256;
    localparam int DEF_BURST_LEN   = 4;
    localparam int DEF_DEPTH_LINES = 1024;
    localparam int DEF_NUM_BANKS   = 4;
    localparam int DEF_ROW_LINES   = 8;
    localparam int DEF_DELAY_MISS  = 10;
    localparam int DEF_DELAY_HIT   = 3;
    function automatic int sel_delay(input logic hit, input int d_hit, input int d_miss);
        return hit ? d_hit : d_miss;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, highest priority at ptr and wrapping upward
module rr_arbiter #(
    parameter int NUM_PORTS = 2,
    localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IW-1:0]        ptr,
    output logic                 valid,
    output logic [IW-1:0]        idx
);
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_PORTS]) begin
                valid = 1'b1;
                idx   = IW'((int'(ptr) + k) % NUM_PORTS);
            end
        end
    end
endmodule

// File: rtl/banked_burst_mem.sv
// banked_burst_mem: banked burst line memory with round-robin ports; BANKED_MEM_ERRCHK_EN enables protocol checking.
module banked_burst_mem import banked_mem_pkg::*; #(
    parameter int NUM_PORTS   = DEF_NUM_PORTS,
    parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int DEPTH_LINES = DEF_DEPTH_LINES,
    parameter int NUM_BANKS   = DEF_NUM_BANKS,
    parameter int ROW_LINES   = DEF_ROW_LINES,
    parameter int DELAY_MISS  = DEF_DELAY_MISS,
    parameter int DELAY_HIT   = DEF_DELAY_HIT,
    localparam int BURST_WIDTH = LINE_WIDTH / BURST_LEN
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_PORTS-1:0]                  read,
    input  logic [NUM_PORTS-1:0]                  write,
    input  logic [NUM_PORTS-1:0][31:0]            addr,
    input  logic [NUM_PORTS-1:0][BURST_WIDTH-1:0] wdata,
    output logic [NUM_PORTS-1:0]                  resp,
    output logic [BURST_WIDTH-1:0]                rdata,
    output logic                                  error,
    output logic [31:0]                           hit_count
);
    localparam int IW  = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
    localparam int LBW = $clog2(DEPTH_LINES);
    localparam int BKW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
    localparam int OFF = $clog2(LINE_WIDTH / 8);
    localparam int RSH = $clog2(NUM_BANKS * ROW_LINES);
    localparam int MW  = $clog2(DEPTH_LINES * BURST_LEN);
`ifdef BANKED_MEM_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic [BURST_WIDTH-1:0] mem [DEPTH_LINES*BURST_LEN];

    state_e                        state_q, state_d;
    logic                          hold_q, hold_d;
    logic [IW-1:0]                 port_q, port_d, ptr_q, ptr_d;
    logic                          op_rd_q, op_rd_d;
    logic [31:0]                   addr_q, addr_d;
    logic [LBW-1:0]                line_q, line_d;
    logic [15:0]                   cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]          resp_q, resp_d;
    logic [BURST_WIDTH-1:0]        rdata_q, rdata_d;
    logic                          error_q, error_d;
    logic [31:0]                   hit_q, hit_d;
    logic [NUM_BANKS-1:0]          open_vld_q, open_vld_d;
    logic [NUM_BANKS-1:0][LBW-1:0] open_row_q, open_row_d;

    logic           gnt_vld, row_hit, abort, idle_both;
    logic [IW-1:0]  gnt_idx;
    logic [LBW-1:0] gnt_line, gnt_row;
    logic [BKW-1:0] gnt_bank;
    logic [MW-1:0]  rd_idx, wr_idx;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .req  (read ^ write),
        .ptr  (ptr_q),
        .valid(gnt_vld),
        .idx  (gnt_idx)
    );

    assign gnt_line  = LBW'(addr[gnt_idx] >> OFF);
    assign gnt_bank  = BKW'(int'(gnt_line) % NUM_BANKS);
    assign gnt_row   = gnt_line >> RSH;
    assign row_hit   = open_vld_q[gnt_bank] && open_row_q[gnt_bank] == gnt_row;
    assign rd_idx    = MW'(int'(line_q) * BURST_LEN + (state_q == WAIT ? 0 : int'(cnt_q) + 1));
    assign wr_idx    = MW'(int'(line_q) * BURST_LEN + int'(cnt_q));
    assign abort     = ERRCHK && state_q != IDLE && (read[port_q] != op_rd_q
                       || write[port_q] == op_rd_q || addr[port_q] != addr_q);
    assign idle_both = ERRCHK && state_q == IDLE && |(read & write);

    always_comb begin
        state_d    = state_q;
        hold_d     = 1'b0;
        port_d     = port_q;
        ptr_d      = ptr_q;
        op_rd_d    = op_rd_q;
        addr_d     = addr_q;
        line_d     = line_q;
        cnt_d      = cnt_q;
        resp_d     = resp_q;
        rdata_d    = rdata_q;
        error_d    = error_q | abort | idle_both;
        hit_d      = hit_q;
        open_vld_d = open_vld_q;
        open_row_d = open_row_q;
        case (state_q)
            IDLE: if (!hold_q && gnt_vld) begin
                state_d              = WAIT;
                port_d               = gnt_idx;
                ptr_d                = IW'((int'(gnt_idx) + 1) % NUM_PORTS);
                op_rd_d              = read[gnt_idx];
                addr_d               = addr[gnt_idx];
                line_d               = gnt_line;
                cnt_d                = 16'(sel_delay(row_hit, DELAY_HIT, DELAY_MISS) - 1);
                hit_d                = hit_q + 32'(row_hit);
                open_vld_d[gnt_bank] = 1'b1;
                open_row_d[gnt_bank] = gnt_row;
            end
            WAIT: if (cnt_q == '0) begin
                state_d = BURST;
                cnt_d   = '0;
                resp_d  = NUM_PORTS'(1) << port_q;
                rdata_d = op_rd_q ? mem[rd_idx] : rdata_q;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
            BURST: if (cnt_q == 16'(BURST_LEN - 1)) begin
                state_d = IDLE;
                resp_d  = '0;
                hold_d  = 1'b1;
            end else begin
                cnt_d   = cnt_q + 16'd1;
                rdata_d = op_rd_q ? mem[rd_idx] : rdata_q;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            resp_d  = '0;
            hold_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_q     <= 1'b0;
            port_q     <= '0;
            ptr_q      <= '0;
            op_rd_q    <= 1'b0;
            addr_q     <= '0;
            line_q     <= '0;
            cnt_q      <= '0;
            resp_q     <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
            hit_q      <= '0;
            open_vld_q <= '0;
            open_row_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            port_q     <= port_d;
            ptr_q      <= ptr_d;
            op_rd_q    <= op_rd_d;
            addr_q     <= addr_d;
            line_q     <= line_d;
            cnt_q      <= cnt_d;
            resp_q     <= resp_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
            hit_q      <= hit_d;
            open_vld_q <= open_vld_d;
            open_row_q <= open_row_d;
        end
    end

    // Reset wins over the beat in flight so an interrupted write keeps only completed beats.
    always_ff @(posedge clk) begin
        if (!rst && !abort && state_q == BURST && !op_rd_q)
            mem[wr_idx] <= wdata[port_q];
    end

    assign resp      = resp_q;
    assign rdata     = rdata_q;
    assign error     = error_q;
    assign hit_count = hit_q;
endmodule
